send_reg_axis: RTL and testbench

- AXI-Stream slave that accepts one DATA_W-bit word per handshake and shifts it out on a two-wire serial link (o_clk/o_data), MSB first.
- Drives APA102/Blinkt-style LED bars from a register value.
- Sits between a register/AXIS source and the LED pins; one word is in flight at a time.

---
 rtl/send_reg_axis_pkg.sv | 19 +
 rtl/send_reg_axis_tick.sv | 33 +++
 rtl/send_reg_axis.sv | 124 ++++++++++++
 tb/tb_send_reg_axis.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/send_reg_axis_pkg.sv
// Shared types and constants for the send_reg_axis serial LED driver.
package send_reg_axis_pkg;

  // Serialiser phases: waiting for a word, o_clk low half, o_clk high half.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

  localparam int DATA_W_DEF  = 32;
  localparam int CLK_DIV_DEF = 4;

  // Bits needed to count 0 .. n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/send_reg_axis_tick.sv
// Half-period timer: while enabled, pulses tick on the last of every
// CLK_DIV cycles. Held cleared while disabled so each phase starts fresh.
module send_reg_axis_tick
  import send_reg_axis_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int                CW   = cnt_w(CLK_DIV);
  localparam logic [CW-1:0]     LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count cycles inside the current half-period; wrap on tick.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/send_reg_axis.sv
// AXI-Stream slave that serialises each accepted DATA_W-bit word onto an
// APA102-style two-wire link (o_clk / o_data). One word in flight at a time.
// Build option: define SEND_REG_AXIS_LSB_FIRST_EN to shift bit 0 first;
// default is MSB first. Timing and handshake are the same either way.
module send_reg_axis
  import send_reg_axis_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              axis_aclk,
  input  logic              axis_reset,
  input  logic [DATA_W-1:0] s_axis_data,
  input  logic              s_axis_valid,
  output logic              s_axis_ready,
  output logic              o_clk,
  output logic              o_data
);

  localparam int            BW       = cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state, state_d;
  logic [DATA_W-1:0] shift, shift_d;
  logic [BW-1:0]     bit_cnt, bit_cnt_d;
  logic              o_clk_d, o_data_d, ready_d;
  logic              tick;

  // Bit that goes on the wire next for a given shift-register value.
  function automatic logic head_bit(input logic [DATA_W-1:0] v);
`ifdef SEND_REG_AXIS_LSB_FIRST_EN
    return v[0];
`else
    return v[DATA_W-1];
`endif
  endfunction

  // Drop the bit just sent so the next one becomes the head.
  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
`ifdef SEND_REG_AXIS_LSB_FIRST_EN
    return v >> 1;
`else
    return v << 1;
`endif
  endfunction

  send_reg_axis_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (axis_aclk),
    .rst_n (axis_reset),
    .en    (state != IDLE),
    .tick  (tick)
  );

  // Next-state and next-output decode; all outputs are registered below.
  always_comb begin
    // NOTE: every target gets a default first so no path infers a latch.
    state_d   = state;
    shift_d   = shift;
    bit_cnt_d = bit_cnt;
    o_clk_d   = o_clk;
    o_data_d  = o_data;
    ready_d   = s_axis_ready;

    unique case (state)
      IDLE: begin
        o_clk_d = 1'b0;
        ready_d = 1'b1;
        if (s_axis_valid && s_axis_ready) begin
          shift_d   = s_axis_data;
          bit_cnt_d = '0;
          o_data_d  = head_bit(s_axis_data);
          ready_d   = 1'b0;
          state_d   = LOW;
        end
      end
      LOW: begin
        if (tick) begin
          o_clk_d = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          o_clk_d = 1'b0;
          if (bit_cnt == LAST_BIT) begin
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            shift_d   = advance(shift);
            bit_cnt_d = bit_cnt + BW'(1);
            o_data_d  = head_bit(advance(shift));
            state_d   = LOW;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge axis_aclk) begin
    if (!axis_reset) begin
      // NOTE: the shift register is cleared too, so an aborted word leaves no residue.
      state        <= IDLE;
      shift        <= '0;
      bit_cnt      <= '0;
      o_clk        <= 1'b0;
      o_data       <= 1'b0;
      s_axis_ready <= 1'b0;
    end else begin
      state        <= state_d;
      shift        <= shift_d;
      bit_cnt      <= bit_cnt_d;
      o_clk        <= o_clk_d;
      o_data       <= o_data_d;
      s_axis_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_send_reg_axis.sv
// Self-checking bench for send_reg_axis: drives AXI-Stream words, recovers
// the serial stream from o_clk rising edges and compares against a model
// of the wire order and transfer timing.
`timescale 1ns/1ps
module tb_send_reg_axis;

  localparam int DATA_W   = 32;
  localparam int CLK_DIV  = 4;
  localparam int BUSY     = 2 * CLK_DIV * DATA_W;
  localparam int WAIT_MAX = BUSY + 50;

  logic              axis_aclk = 1'b0;
  logic              axis_reset;
  logic [DATA_W-1:0] s_axis_data;
  logic              s_axis_valid;
  logic              s_axis_ready;
  logic              o_clk;
  logic              o_data;

  int errors = 0;
  int checks = 0;

  always #5 axis_aclk = ~axis_aclk;

  send_reg_axis #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .axis_aclk    (axis_aclk),
    .axis_reset   (axis_reset),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .o_clk        (o_clk),
    .o_data       (o_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: the word as it appears on the wire, first bit in the MSB slot.
  function automatic logic [DATA_W-1:0] wire_order(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
`ifdef SEND_REG_AXIS_LSB_FIRST_EN
    for (int i = 0; i < DATA_W; i++) r[DATA_W-1-i] = w[i];
`else
    r = w;
`endif
    return r;
  endfunction

  // Offers a word, then watches the whole transfer. Called just after a
  // falling edge; returns at the falling edge where ready is seen high again.
  task automatic send_word(input logic [DATA_W-1:0] word, input logic [DATA_W-1:0] busy_data,
                           input bit hold, input bit b2b, input string tag);
    int                waited = 0;
    int                low = 0;
    int                rises = 0;
    int                first_rise = -1;
    int                unstable = 0;
    logic              prev_clk;
    logic              prev_data;
    logic [DATA_W-1:0] rx = '0;
    logic [DATA_W-1:0] expw;

    expw         = wire_order(word);
    s_axis_data  = word;
    s_axis_valid = 1'b1;
    while (!s_axis_ready && waited < WAIT_MAX) begin
      @(negedge axis_aclk);
      waited++;
    end
    if (b2b) begin
      check({tag, ":gap_wait"}, 64'(waited), 64'd0);
      check({tag, ":gap_oclk"}, 64'(o_clk), 64'd0);
    end
    if (!s_axis_ready) begin
      check({tag, ":ready_timeout"}, 64'd0, 64'd1);
      s_axis_valid = 1'b0;
      return;
    end

    @(negedge axis_aclk);
    check({tag, ":first_bit"}, 64'(o_data), 64'(expw[DATA_W-1]));
    if (!hold) s_axis_valid = 1'b0;
    s_axis_data = busy_data;

    prev_clk  = o_clk;
    prev_data = o_data;
    while (!s_axis_ready && low < WAIT_MAX) begin
      low++;
      if (o_clk && !prev_clk) begin
        if (first_rise < 0) first_rise = low;
        if (o_data !== prev_data) unstable++;
        rx = {rx[DATA_W-2:0], o_data};
        rises++;
      end
      prev_clk  = o_clk;
      prev_data = o_data;
      @(negedge axis_aclk);
    end

    check({tag, ":rises"}, 64'(rises), 64'(DATA_W));
    check({tag, ":bits"}, 64'(rx), 64'(expw));
    check({tag, ":ready_low"}, 64'(low), 64'(BUSY));
    check({tag, ":first_rise"}, 64'(first_rise), 64'(CLK_DIV + 1));
    check({tag, ":unstable"}, 64'(unstable), 64'd0);
    check({tag, ":idle_oclk"}, 64'(o_clk), 64'd0);
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int               rises;
    int               spin;
    int               idle_bad;
    logic             prev_clk;
    logic [DATA_W-1:0] w;

    axis_reset   = 1'b0;
    s_axis_valid = 1'b0;
    s_axis_data  = '0;

    // Reset held for five cycles with valid asserted to show it is ignored.
    s_axis_valid = 1'b1;
    s_axis_data  = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge axis_aclk);
      check($sformatf("rst%0d:ready", i), 64'(s_axis_ready), 64'd0);
      check($sformatf("rst%0d:oclk", i), 64'(o_clk), 64'd0);
      check($sformatf("rst%0d:odata", i), 64'(o_data), 64'd0);
    end
    s_axis_valid = 1'b0;
    axis_reset   = 1'b1;
    @(negedge axis_aclk);
    check("rel:ready", 64'(s_axis_ready), 64'd1);
    check("rel:oclk", 64'(o_clk), 64'd0);

    // Single word with only the end bits set.
    send_word(32'h8000_0001, 32'h0, 1'b0, 1'b0, "w8001");

    // Valid low while ready is high: nothing must start.
    idle_bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge axis_aclk);
      if (!s_axis_ready || o_clk) idle_bad++;
    end
    check("novalid:idle", 64'(idle_bad), 64'd0);

    // Back-to-back words with valid held high; second word also sees
    // all-ones on the data bus while busy.
    send_word(32'hA5A5_A5A5, 32'h0, 1'b1, 1'b0, "wA5");
    send_word(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, "w0");

    // Single low bit as a bit-order probe.
    send_word(32'h0000_0001, 32'hDEAD_BEEF, 1'b0, 1'b0, "w0001");

    // Reset after ten rising edges aborts the word.
    s_axis_data  = 32'hFFFF_FFFF;
    s_axis_valid = 1'b1;
    @(negedge axis_aclk);
    s_axis_valid = 1'b0;
    rises    = 0;
    spin     = 0;
    prev_clk = o_clk;
    while (rises < 10 && spin < WAIT_MAX) begin
      @(negedge axis_aclk);
      spin++;
      if (o_clk && !prev_clk) rises++;
      prev_clk = o_clk;
    end
    check("abort:reached", 64'(rises), 64'd10);
    axis_reset = 1'b0;
    @(negedge axis_aclk);
    check("abort:oclk", 64'(o_clk), 64'd0);
    check("abort:ready", 64'(s_axis_ready), 64'd0);
    check("abort:odata", 64'(o_data), 64'd0);
    @(negedge axis_aclk);
    axis_reset = 1'b1;
    @(negedge axis_aclk);
    check("abort:rel_ready", 64'(s_axis_ready), 64'd1);
    send_word(32'h1234_5678, 32'h0, 1'b0, 1'b0, "fresh");

    // Random words, randomly chained back-to-back.
    begin
      bit prev_hold = 1'b0;
      for (int n = 0; n < 5; n++) begin
        bit h;
        h = (n < 4) ? bit'($urandom_range(0, 1)) : 1'b0;
        w = $urandom;
        send_word(w, $urandom, h, prev_hold, $sformatf("rnd%0d", n));
        prev_hold = h;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
